mod_updown_counter: RTL and testbench
=====================================

# mod_updown_counter

Parametrised modulo-N up/down counter for the clock/timer datapath of the VGA monitor. Replaces the fixed 6-bit mod-60 counter: modulus and width are parameters, counting is fully synchronous to a single clock, and the block adds a parallel load, a cascade strobe for chaining seconds→minutes→hours, and one-cycle wrap pulses. The manual-increment button input is edge-detected internally instead of being used as a clock.

## Interface
- MODULUS, 60, count range 0..MODULUS-1; legal 2..2^WIDTH
- WIDTH, 6, counter width; must satisfy 2^WIDTH >= MODULUS
- RESET_VALUE, 0, value of out after reset; must be < MODULUS

- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high; fixed polarity and synchronicity
- enable  in  1  gates all count and load activity
- forward  in  1  1 = count up, 0 = count down
- tick  in  1  single-cycle count strobe (1 Hz base, or wrap_out of a lower stage)
- increment  in  1  level input (debounced button); each rising edge is one count event
- load  in  1  parallel load strobe
- load_value  in  WIDTH  value for load
- out  out  WIDTH  current count, registered
- wrap_out  out  1  one-cycle pulse when the count wraps (either direction)
- finish  out  1  registered sticky flag: a down-count wrapped 0→MODULUS-1

## Operation
- Count event = enable & (tick | inc_rise), where inc_rise = increment & ~increment_q. tick and inc_rise in the same cycle give exactly one step.
- Priority per cycle: reset > load > count event > hold.
- reset: out=RESET_VALUE, wrap_out=0, finish=0, increment_q=0.
- load (enable=1): out = min(load_value, MODULUS-1); finish=0; wrap_out=0; a coincident count event is discarded. load with enable=0 is ignored.
- Up (forward=1): out<MODULUS-1 → out+1; out==MODULUS-1 → 0 with wrap_out=1.
- Down (forward=0): out>0 → out-1; out==0 → MODULUS-1 with wrap_out=1 and finish=1.
- finish stays set until reset or load; up-counting never clears it.
- Changing forward between events needs no resynchronisation: the direction applies from the next event on the current out value (no shadow registers).
- Arithmetic in WIDTH bits; compares against MODULUS-1 and 0 only, so out never leaves 0..MODULUS-1 after reset.
- enable=0: out, finish held; wrap_out=0; increment_q keeps tracking increment, so a button held across enable rising does not produce a count.

## Timing
- Event sampled at rising edge k → out, wrap_out, finish valid after edge k (1-cycle latency from input to register).
- inc_rise uses increment_q registered at edge k-1; increment must be synchronous to clk (synchroniser lives upstream).
- wrap_out high for exactly the cycle after the wrapping edge; it is fit to drive tick of the next stage, giving one-cycle ripple per stage.
- Back-to-back tick every cycle is legal: one step per cycle.
- Reset mid-count: next edge forces RESET_VALUE regardless of other inputs.

## Structure
- Package counter_pkg: DIR_UP/DIR_DOWN constants, default MODULUS values (SEC_MOD=60, MIN_MOD=60, HOUR_MOD=24), helper for clamp.
- Sub-module rise_detect (clk, reset, in, rise): registered previous value, rise = in & ~prev; reused by other button-driven blocks.
- Top level holds count register, next-state logic, finish flag, wrap_out register.

## Test plan
- Reset with RESET_VALUE=0, then 60 ticks, forward=1 → out 0..59, then 0; wrap_out single pulse exactly after the 59→0 edge; finish stays 0.
- forward=0 from out=1, two ticks → out 0 then 59; wrap_out and finish 1 after the second edge; 3 up ticks → out 0,1,2, finish still 1.
- increment held high 10 cycles with tick idle → exactly one step; tick and inc_rise in the same cycle → one step.
- load=1, load_value=63 (MODULUS=60) with coincident tick → out=59, finish cleared, no step; load with enable=0 → out unchanged.
- MODULUS=24, WIDTH=5 chained from a MODULUS=60 stage via wrap_out→tick; from 59:23 one tick → 00:00 and both wrap pulses, upper one cycle later.
- reset asserted mid-sequence together with load and tick → out=RESET_VALUE, finish=0, wrap_out=0 after that edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the clock/timer counter chain.
// Direction encodings, default per-stage moduli, and the load-value clamp.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned SEC_MOD  = 60;
  localparam int unsigned MIN_MOD  = 60;
  localparam int unsigned HOUR_MOD = 24;

  // Saturate a requested value into the legal count range 0..modulus-1.
  function automatic int unsigned clamp_to_mod(input int unsigned value,
                                               input int unsigned modulus);
    return (value > modulus - 1) ? modulus - 1 : value;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a clk-synchronous level input (e.g. debounced button).
// rise is combinational from the registered previous value; prev always tracks in.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= in;
  end

  assign rise = in & ~prev;

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with parallel load, wrap pulse and sticky down-wrap flag.
// One-cycle latency from tick/increment/load to out; no backpressure, one step per event.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned MODULUS     = SEC_MOD,
  parameter int unsigned WIDTH       = 6,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             forward,
  input  logic             tick,
  input  logic             increment,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] out,
  output logic             wrap_out,
  output logic             finish
);

  localparam logic [WIDTH-1:0] MAX_COUNT  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] INIT_COUNT = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

  logic             inc_rise;
  logic             count_event;
  logic             load_accept;
  logic [WIDTH-1:0] load_clamped;
  logic             at_top;
  logic             at_zero;
  logic [WIDTH-1:0] step_val;
  logic             step_wrap;

  // Edge tracking runs regardless of enable so a held button never counts on enable rising.
  rise_detect u_inc_rise (
    .clk   (clk),
    .reset (reset),
    .in    (increment),
    .rise  (inc_rise)
  );

  assign count_event  = enable & (tick | inc_rise);
  assign load_accept  = enable & load;
  assign load_clamped = WIDTH'(clamp_to_mod(32'(load_value), MODULUS));

  assign at_top  = (out == MAX_COUNT);
  assign at_zero = (out == '0);

  always_comb begin
    step_val  = out;
    step_wrap = 1'b0;
    if (forward == DIR_UP) begin
      step_wrap = at_top;
      step_val  = at_top ? '0 : out + ONE;
    end else begin
      step_wrap = at_zero;
      step_val  = at_zero ? MAX_COUNT : out - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out      <= INIT_COUNT;
      wrap_out <= 1'b0;
      finish   <= 1'b0;
    end else if (load_accept) begin
      out      <= load_clamped;
      wrap_out <= 1'b0;
      finish   <= 1'b0;
    end else if (count_event) begin
      out      <= step_val;
      wrap_out <= step_wrap;
      // Only a down-count wrap sets the flag; up-counting never clears it.
      if (step_wrap && (forward == DIR_DOWN)) finish <= 1'b1;
    end else begin
      wrap_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench: a mod-60 stage chained into a mod-24 stage through wrap_out.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable, forward, tick, increment, load;
  logic [5:0] load_value;
  logic [5:0] out;
  logic       wrap_out, finish;

  logic       hr_enable, hr_forward, hr_load;
  logic [4:0] hr_load_value;
  logic [4:0] hr_out;
  logic       hr_wrap, hr_finish;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.MODULUS(60), .WIDTH(6), .RESET_VALUE(0)) u_sec (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .forward    (forward),
    .tick       (tick),
    .increment  (increment),
    .load       (load),
    .load_value (load_value),
    .out        (out),
    .wrap_out   (wrap_out),
    .finish     (finish)
  );

  mod_updown_counter #(.MODULUS(24), .WIDTH(5), .RESET_VALUE(0)) u_hour (
    .clk        (clk),
    .reset      (reset),
    .enable     (hr_enable),
    .forward    (hr_forward),
    .tick       (wrap_out),
    .increment  (1'b0),
    .load       (hr_load),
    .load_value (hr_load_value),
    .out        (hr_out),
    .wrap_out   (hr_wrap),
    .finish     (hr_finish)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; forward = 1'b1; tick = 1'b1; increment = 1'b0;
    load = 1'b1; load_value = 6'd33;
    hr_enable = 1'b1; hr_forward = 1'b1; hr_load = 1'b1; hr_load_value = 5'd9;
    step();
    step();
    n_vec++; if (out !== 6'd0) begin n_miss++; $display("FAIL reset_out: got %0d want 0", out); end
    n_vec++; if (wrap_out !== 1'b0) begin n_miss++; $display("FAIL reset_wrap: got %b want 0", wrap_out); end
    n_vec++; if (finish !== 1'b0) begin n_miss++; $display("FAIL reset_finish: got %b want 0", finish); end
    n_vec++; if (hr_out !== 5'd0) begin n_miss++; $display("FAIL reset_hr_out: got %0d want 0", hr_out); end
    reset = 1'b0; tick = 1'b0; load = 1'b0; hr_load = 1'b0; hr_enable = 1'b0;
  endtask

  task automatic test_count_up();
    forward = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick = 1'b1;
      step();
      n_vec++; if (out !== 6'(i % 60)) begin n_miss++; $display("FAIL up_out[%0d]: got %0d want %0d", i, out, i % 60); end
      n_vec++; if (wrap_out !== (i == 60)) begin n_miss++; $display("FAIL up_wrap[%0d]: got %b want %b", i, wrap_out, (i == 60)); end
      n_vec++; if (finish !== 1'b0) begin n_miss++; $display("FAIL up_finish[%0d]: got %b want 0", i, finish); end
    end
    tick = 1'b0;
    step();
    n_vec++; if (wrap_out !== 1'b0) begin n_miss++; $display("FAIL up_wrap_clear: got %b want 0", wrap_out); end
  endtask

  task automatic test_count_down();
    load = 1'b1; load_value = 6'd1;
    step();
    load = 1'b0;
    n_vec++; if (out !== 6'd1) begin n_miss++; $display("FAIL dn_load1: got %0d want 1", out); end
    forward = 1'b0; tick = 1'b1;
    step();
    n_vec++; if (out !== 6'd0) begin n_miss++; $display("FAIL dn_out0: got %0d want 0", out); end
    n_vec++; if (wrap_out !== 1'b0) begin n_miss++; $display("FAIL dn_wrap0: got %b want 0", wrap_out); end
    n_vec++; if (finish !== 1'b0) begin n_miss++; $display("FAIL dn_finish0: got %b want 0", finish); end
    step();
    n_vec++; if (out !== 6'd59) begin n_miss++; $display("FAIL dn_out59: got %0d want 59", out); end
    n_vec++; if (wrap_out !== 1'b1) begin n_miss++; $display("FAIL dn_wrap59: got %b want 1", wrap_out); end
    n_vec++; if (finish !== 1'b1) begin n_miss++; $display("FAIL dn_finish59: got %b want 1", finish); end
    forward = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (out !== 6'(i)) begin n_miss++; $display("FAIL dn_up_out[%0d]: got %0d want %0d", i, out, i); end
      n_vec++; if (wrap_out !== (i == 0)) begin n_miss++; $display("FAIL dn_up_wrap[%0d]: got %b want %b", i, wrap_out, (i == 0)); end
      n_vec++; if (finish !== 1'b1) begin n_miss++; $display("FAIL dn_up_finish[%0d]: got %b want 1", i, finish); end
    end
    tick = 1'b0;
  endtask

  task automatic test_increment();
    forward = 1'b1; increment = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++; if (out !== 6'd3) begin n_miss++; $display("FAIL inc_hold[%0d]: got %0d want 3", i, out); end
    end
    increment = 1'b0;
    step();
    n_vec++; if (out !== 6'd3) begin n_miss++; $display("FAIL inc_fall: got %0d want 3", out); end
    increment = 1'b1; tick = 1'b1;
    step();
    n_vec++; if (out !== 6'd4) begin n_miss++; $display("FAIL inc_tick_same: got %0d want 4", out); end
    increment = 1'b0; tick = 1'b0;
    step();
    enable = 1'b0; increment = 1'b1;
    step();
    n_vec++; if (out !== 6'd4) begin n_miss++; $display("FAIL inc_disabled: got %0d want 4", out); end
    enable = 1'b1;
    step();
    n_vec++; if (out !== 6'd4) begin n_miss++; $display("FAIL inc_enable_rise: got %0d want 4", out); end
    increment = 1'b0;
    step();
  endtask

  task automatic test_load();
    n_vec++; if (finish !== 1'b1) begin n_miss++; $display("FAIL ld_pre_finish: got %b want 1", finish); end
    load = 1'b1; load_value = 6'd63; tick = 1'b1; forward = 1'b1;
    step();
    n_vec++; if (out !== 6'd59) begin n_miss++; $display("FAIL ld_clamp: got %0d want 59", out); end
    n_vec++; if (finish !== 1'b0) begin n_miss++; $display("FAIL ld_finish: got %b want 0", finish); end
    n_vec++; if (wrap_out !== 1'b0) begin n_miss++; $display("FAIL ld_wrap: got %b want 0", wrap_out); end
    enable = 1'b0; load_value = 6'd10;
    step();
    n_vec++; if (out !== 6'd59) begin n_miss++; $display("FAIL ld_disabled: got %0d want 59", out); end
    n_vec++; if (wrap_out !== 1'b0) begin n_miss++; $display("FAIL ld_disabled_wrap: got %b want 0", wrap_out); end
    enable = 1'b1; tick = 1'b0; load_value = 6'd7;
    step();
    n_vec++; if (out !== 6'd7) begin n_miss++; $display("FAIL ld_inrange: got %0d want 7", out); end
    load = 1'b0;
  endtask

  task automatic test_chain();
    forward = 1'b1; hr_forward = 1'b1; hr_enable = 1'b1;
    load = 1'b1; load_value = 6'd59; hr_load = 1'b1; hr_load_value = 5'd23;
    step();
    load = 1'b0; hr_load = 1'b0;
    n_vec++; if (out !== 6'd59 || hr_out !== 5'd23) begin n_miss++; $display("FAIL ch_preload: got %0d:%0d want 59:23", out, hr_out); end
    tick = 1'b1;
    step();
    tick = 1'b0;
    n_vec++; if (out !== 6'd0 || wrap_out !== 1'b1) begin n_miss++; $display("FAIL ch_sec_wrap: got out=%0d wrap=%b want 0/1", out, wrap_out); end
    n_vec++; if (hr_out !== 5'd23 || hr_wrap !== 1'b0) begin n_miss++; $display("FAIL ch_hr_early: got out=%0d wrap=%b want 23/0", hr_out, hr_wrap); end
    step();
    n_vec++; if (hr_out !== 5'd0 || hr_wrap !== 1'b1) begin n_miss++; $display("FAIL ch_hr_wrap: got out=%0d wrap=%b want 0/1", hr_out, hr_wrap); end
    n_vec++; if (wrap_out !== 1'b0 || hr_finish !== 1'b0) begin n_miss++; $display("FAIL ch_sec_clear: got wrap=%b hr_finish=%b want 0/0", wrap_out, hr_finish); end
    step();
    n_vec++; if (hr_wrap !== 1'b0 || hr_out !== 5'd0) begin n_miss++; $display("FAIL ch_hr_clear: got out=%0d wrap=%b want 0/0", hr_out, hr_wrap); end
    hr_enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    forward = 1'b0; tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (out !== 6'(59 - i)) begin n_miss++; $display("FAIL b2b_out[%0d]: got %0d want %0d", i, out, 59 - i); end
      n_vec++; if (wrap_out !== (i == 0)) begin n_miss++; $display("FAIL b2b_wrap[%0d]: got %b want %b", i, wrap_out, (i == 0)); end
      n_vec++; if (finish !== 1'b1) begin n_miss++; $display("FAIL b2b_finish[%0d]: got %b want 1", i, finish); end
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; load = 1'b1; load_value = 6'd20; tick = 1'b1; enable = 1'b1;
    hr_enable = 1'b1; hr_load = 1'b1; hr_load_value = 5'd5;
    step();
    n_vec++; if (out !== 6'd0) begin n_miss++; $display("FAIL rmid_out: got %0d want 0", out); end
    n_vec++; if (finish !== 1'b0) begin n_miss++; $display("FAIL rmid_finish: got %b want 0", finish); end
    n_vec++; if (wrap_out !== 1'b0) begin n_miss++; $display("FAIL rmid_wrap: got %b want 0", wrap_out); end
    n_vec++; if (hr_out !== 5'd0) begin n_miss++; $display("FAIL rmid_hr_out: got %0d want 0", hr_out); end
    reset = 1'b0; load = 1'b0; tick = 1'b0; hr_load = 1'b0; hr_enable = 1'b0;
    step();
    n_vec++; if (out !== 6'd0) begin n_miss++; $display("FAIL rmid_idle: got %0d want 0", out); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_increment();
    test_load();
    test_chain();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
